multi_temp_monitor: RTL

MULTI_TEMP_MONITOR -- requirements
Module: multi_temp_monitor

---
 rtl/multi_temp_monitor.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/multi_temp_monitor.sv
// multi_temp_monitor: per-channel thermal zone tracker (NORMAL/WARN/CRIT) with
// persistence-qualified escalation, hysteretic de-escalation, aggregate alarm/fan
// requests, a sticky overheat latch and a running hottest-channel report.
// Optional feature macro FAN_PWM_EN: adds an 8-bit PWM fan drive; without it
// fan_pwm simply follows fan_on.
module multi_temp_monitor #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned WARN_TEMP = 500,
  parameter int unsigned CRIT_TEMP = 800,
  parameter int unsigned HYST      = 20,
  parameter int unsigned PERSIST   = 3,
  localparam int unsigned CH_W     = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      temp_in,
  input  logic [CH_W-1:0]       temp_ch,
  input  logic                  temp_valid,
  input  logic                  clear_latch,
  output logic [2*CHANNELS-1:0] zone_out,
  output logic                  fan_on,
  output logic                  alarm,
  output logic                  overheat_latched,
  output logic [WIDTH-1:0]      max_temp,
  output logic [CH_W-1:0]       max_ch,
  output logic                  sample_err,
  output logic                  fan_pwm
);

  typedef enum logic [1:0] {ZoneNormal = 2'd0, ZoneWarn = 2'd1, ZoneCrit = 2'd2} zone_e;

  localparam logic [WIDTH-1:0] WarnT    = WIDTH'(WARN_TEMP);
  localparam logic [WIDTH-1:0] CritT    = WIDTH'(CRIT_TEMP);
  localparam logic [WIDTH-1:0] WarnLo   = WIDTH'(WARN_TEMP - HYST);
  localparam logic [WIDTH-1:0] CritLo   = WIDTH'(CRIT_TEMP - HYST);
  localparam logic [3:0]       PersistC = 4'(PERSIST);

  zone_e            zone_q [CHANNELS];
  zone_e            zone_d [CHANNELS];
  // Lowest target seen in the current escalation run; mixed runs settle on it.
  zone_e            pend_q [CHANNELS];
  zone_e            pend_d [CHANNELS];
  logic [3:0]       cnt_q  [CHANNELS];
  logic [3:0]       cnt_d  [CHANNELS];
  logic [WIDTH-1:0] samp_q [CHANNELS];
  logic [WIDTH-1:0] samp_d [CHANNELS];

  zone_e            tgt;
  logic             any_crit;
  logic             any_warn;
  logic [WIDTH-1:0] max_v;
  logic [CH_W-1:0]  max_i;
  logic             err_d;
  logic             latched_d;

  // Classify the incoming sample against the absolute thresholds.
  always_comb begin
    tgt = ZoneNormal;
    if (temp_in >= CritT) tgt = ZoneCrit;
    else if (temp_in >= WarnT) tgt = ZoneWarn;
  end

  // Per-channel next state: only the addressed channel moves on a valid sample.
  always_comb begin
    zone_e run_min;
    run_min = ZoneNormal;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      zone_d[i] = zone_q[i];
      pend_d[i] = pend_q[i];
      cnt_d[i]  = cnt_q[i];
      samp_d[i] = samp_q[i];
      if (temp_valid && 32'(temp_ch) == i) begin
        samp_d[i] = temp_in;
        if (tgt > zone_q[i]) begin
          run_min = (cnt_q[i] == 4'd0 || tgt < pend_q[i]) ? tgt : pend_q[i];
          if (cnt_q[i] + 4'd1 == PersistC) begin
            zone_d[i] = run_min;
            cnt_d[i]  = 4'd0;
            pend_d[i] = ZoneNormal;
          end else begin
            cnt_d[i]  = cnt_q[i] + 4'd1;
            pend_d[i] = run_min;
          end
        end else begin
          cnt_d[i]  = 4'd0;
          pend_d[i] = ZoneNormal;
          if (temp_in < WarnLo) zone_d[i] = ZoneNormal;
          else if (zone_q[i] == ZoneCrit && temp_in < CritLo) zone_d[i] = ZoneWarn;
        end
      end
    end
  end

  // Aggregate zone flags, hottest stored sample (lowest index wins ties), latch and error.
  always_comb begin
    any_crit = 1'b0;
    any_warn = 1'b0;
    max_v    = samp_q[0];
    max_i    = '0;
    zone_out = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      zone_out[2*i +: 2] = zone_q[i];
      if (zone_q[i] == ZoneCrit) any_crit = 1'b1;
      if (zone_q[i] != ZoneNormal) any_warn = 1'b1;
      if (samp_q[i] > max_v) begin
        max_v = samp_q[i];
        max_i = CH_W'(i);
      end
    end
    err_d     = temp_valid && (32'(temp_ch) >= CHANNELS);
    // A new alarm overrides a concurrent clear request.
    latched_d = any_crit | (overheat_latched & ~clear_latch);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        zone_q[i] <= ZoneNormal;
        pend_q[i] <= ZoneNormal;
        cnt_q[i]  <= 4'd0;
        samp_q[i] <= '0;
      end
      alarm            <= 1'b0;
      fan_on           <= 1'b0;
      overheat_latched <= 1'b0;
      max_temp         <= '0;
      max_ch           <= '0;
      sample_err       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        zone_q[i] <= zone_d[i];
        pend_q[i] <= pend_d[i];
        cnt_q[i]  <= cnt_d[i];
        samp_q[i] <= samp_d[i];
      end
      alarm            <= any_crit;
      fan_on           <= any_warn;
      overheat_latched <= latched_d;
      max_temp         <= max_v;
      max_ch           <= max_i;
      sample_err       <= err_d;
    end
  end

`ifdef FAN_PWM_EN
  logic [7:0] pwm_cnt_q;
  logic       fan_pwm_q;

  // Free-running PWM counter; worst zone picks duty (CRIT full on, WARN half).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= 8'd0;
      fan_pwm_q <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      fan_pwm_q <= any_crit ? 1'b1 : (any_warn ? (pwm_cnt_q < 8'd128) : 1'b0);
    end
  end

  assign fan_pwm = fan_pwm_q;
`else
  assign fan_pwm = fan_on;
`endif

endmodule
